// File: rtl/ifu_fetch_port.sv
// rtl/ifu_fetch_port.sv - IFU instruction-fetch port: one AXI4-Lite read per fetch request
module ifu_fetch_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reqValid,
    input  logic [ADDR_W-1:0] pc,
    output logic              respValid,
    output logic [DATA_W-1:0] inst,
    output logic              fetch_err,
    output logic              busy,
    output logic [31:0]       fetch_count,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // A PC that is not word aligned faults without touching the bus
    logic misaligned;
    assign misaligned = (pc[1:0] != 2'b00);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; only one transaction in flight, stray inputs ignored per state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (reqValid) begin
                    state_next = misaligned ? RESP : ADDR;
                end
            end
            ADDR: begin
                if (arready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (rvalid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus strobes and status come straight from the state register
    assign arvalid   = (state == ADDR);
    assign rready    = (state == DATA);
    assign respValid = (state == RESP);
    assign busy      = (state != IDLE);

    // Datapath: address capture, response capture, and the completion counter,
    // which is bumped on entry to RESP so it already reflects this response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            araddr      <= '0;
            inst        <= '0;
            fetch_err   <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        if (misaligned) begin
                            inst        <= '0;
                            fetch_err   <= 1'b1;
                            fetch_count <= fetch_count + 32'd1;
                        end else begin
                            araddr <= pc;
                        end
                    end
                end
                DATA: begin
                    if (rvalid) begin
                        inst        <= rdata;
                        fetch_err   <= (rresp != 2'b00);
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch_port.sv
// tb/tb_ifu_fetch_port.sv - self-checking bench for ifu_fetch_port
module tb_ifu_fetch_port;

    logic        clock;
    logic        reset;
    logic        reqValid;
    logic [31:0] pc;
    logic        respValid;
    logic [31:0] inst;
    logic        fetch_err;
    logic        busy;
    logic [31:0] fetch_count;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    ifu_fetch_port #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .reqValid    (reqValid),
        .pc          (pc),
        .respValid   (respValid),
        .inst        (inst),
        .fetch_err   (fetch_err),
        .busy        (busy),
        .fetch_count (fetch_count),
        .araddr      (araddr),
        .arvalid     (arvalid),
        .arready     (arready),
        .rdata       (rdata),
        .rresp       (rresp),
        .rvalid      (rvalid),
        .rready      (rready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the port should be showing
    logic [31:0] exp_count = 32'd0;
    logic [31:0] last_inst = 32'd0;
    logic        last_err  = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_dly;
        int          r_dly;
        bit          spur;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One fetch, starting and ending at a negedge with the port idle.
    // Every cycle of the transaction is checked against the timing rules.
    task automatic do_fetch(input logic [31:0] p, input logic [31:0] d, input logic [1:0] r,
                            input int d1, input int d2, input bit spur,
                            input logic [31:0] e_inst, input logic e_err);
        reqValid = 1'b1;
        pc       = p;
        @(negedge clock);
        reqValid = 1'b0;
        pc       = $urandom;
        if (p[1:0] != 2'b00) begin
            exp_count = exp_count + 32'd1;
            chk("mis_resp", {31'd0, respValid}, 32'd1);
            chk("mis_arvalid", {31'd0, arvalid}, 32'd0);
            chk("mis_inst", inst, e_inst);
            chk("mis_err", {31'd0, fetch_err}, {31'd0, e_err});
            chk("mis_count", fetch_count, exp_count);
            chk("mis_busy", {31'd0, busy}, 32'd1);
        end else begin
            for (int k = 0; k <= d1; k++) begin
                chk("addr_arvalid", {31'd0, arvalid}, 32'd1);
                chk("addr_araddr", araddr, p);
                chk("addr_rready", {31'd0, rready}, 32'd0);
                chk("addr_resp", {31'd0, respValid}, 32'd0);
                chk("addr_busy", {31'd0, busy}, 32'd1);
                arready = (k == d1);
                if (spur) begin
                    reqValid = 1'b1;
                    pc       = p + 32'h100;
                    rvalid   = 1'b1;
                    rdata    = $urandom;
                    rresp    = 2'b10;
                end
                @(negedge clock);
                arready  = 1'b0;
                reqValid = 1'b0;
                rvalid   = 1'b0;
            end
            for (int k = 0; k <= d2; k++) begin
                chk("data_rready", {31'd0, rready}, 32'd1);
                chk("data_arvalid", {31'd0, arvalid}, 32'd0);
                chk("data_resp", {31'd0, respValid}, 32'd0);
                chk("data_busy", {31'd0, busy}, 32'd1);
                rvalid = (k == d2);
                rdata  = (k == d2) ? d : $urandom;
                rresp  = (k == d2) ? r : 2'(3 - r);
                @(negedge clock);
                rvalid = 1'b0;
                rdata  = $urandom;
            end
            exp_count = exp_count + 32'd1;
            chk("resp_valid", {31'd0, respValid}, 32'd1);
            chk("resp_inst", inst, e_inst);
            chk("resp_err", {31'd0, fetch_err}, {31'd0, e_err});
            chk("resp_count", fetch_count, exp_count);
            chk("resp_arvalid", {31'd0, arvalid}, 32'd0);
            chk("resp_rready", {31'd0, rready}, 32'd0);
        end
        last_inst = e_inst;
        last_err  = e_err;
        // A request during the response cycle must be ignored
        if (spur) begin
            reqValid = 1'b1;
            pc       = 32'h0000_1000;
        end
        @(negedge clock);
        reqValid = 1'b0;
        chk("post_resp", {31'd0, respValid}, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_arvalid", {31'd0, arvalid}, 32'd0);
        chk("post_inst", inst, last_inst);
        chk("post_err", {31'd0, fetch_err}, {31'd0, last_err});
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_resp", {31'd0, respValid}, 32'd0);
            chk("idle_inst", inst, last_inst);
            chk("idle_err", {31'd0, fetch_err}, {31'd0, last_err});
            @(negedge clock);
        end
    endtask

    initial begin
        vecs[0] = '{32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 1'b0, 32'h0000_0413, 1'b0};
        vecs[1] = '{32'h8000_0004, 32'h0010_0093, 2'b00, 2, 3, 1'b0, 32'h0010_0093, 1'b0};
        vecs[2] = '{32'h8000_0002, 32'h1234_5678, 2'b00, 0, 0, 1'b0, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h8000_0008, 32'hDEAD_BEEF, 2'b10, 1, 0, 1'b0, 32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{32'h8000_000C, 32'h0000_0013, 2'b00, 0, 1, 1'b0, 32'h0000_0013, 1'b0};
        vecs[5] = '{32'h8000_0010, 32'hCAFE_F00D, 2'b00, 1, 1, 1'b1, 32'hCAFE_F00D, 1'b0};

        reset    = 1'b1;
        reqValid = 1'b0;
        pc       = 32'd0;
        arready  = 1'b0;
        rdata    = 32'd0;
        rresp    = 2'b00;
        rvalid   = 1'b0;

        // Reset state
        #1;
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_resp", {31'd0, respValid}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        idle_cycles(2);

        // Directed vectors
        foreach (vecs[i]) begin
            do_fetch(vecs[i].pc, vecs[i].rdata, vecs[i].rresp, vecs[i].ar_dly, vecs[i].r_dly,
                     vecs[i].spur, vecs[i].exp_inst, vecs[i].exp_err);
        end

        // Reset while waiting for read data
        reqValid = 1'b1;
        pc       = 32'h8000_0020;
        @(negedge clock);
        reqValid = 1'b0;
        arready  = 1'b1;
        @(negedge clock);
        arready  = 1'b0;
        chk("mid_rready", {31'd0, rready}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_arvalid", {31'd0, arvalid}, 32'd0);
        chk("mid_rready0", {31'd0, rready}, 32'd0);
        chk("mid_resp", {31'd0, respValid}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_count", fetch_count, 32'd0);
        chk("mid_inst", inst, 32'd0);
        @(negedge clock);
        reset     = 1'b0;
        exp_count = 32'd0;
        last_inst = 32'd0;
        last_err  = 1'b0;
        idle_cycles(1);
        do_fetch(32'h8000_0024, 32'h0000_0517, 2'b00, 0, 0, 1'b0, 32'h0000_0517, 1'b0);

        // Counter wrap: preload the count to all ones, next response wraps to zero
        force dut.fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count;
        exp_count = 32'hFFFF_FFFF;
        chk("preload_count", fetch_count, 32'hFFFF_FFFF);
        @(negedge clock);
        do_fetch(32'h8000_0028, 32'h0000_0297, 2'b00, 0, 0, 1'b0, 32'h0000_0297, 1'b0);
        chk("wrap_count", fetch_count, 32'd0);

        // Randomized fetches against the reference rules
        for (int t = 0; t < 60; t++) begin
            logic [31:0] rp;
            logic [31:0] rd;
            logic [1:0]  rr;
            logic [31:0] e_i;
            logic        e_e;
            rp = $urandom;
            if ($urandom_range(3) != 0) begin
                rp[1:0] = 2'b00;
            end
            rd = $urandom;
            rr = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'b00;
            if (rp[1:0] != 2'b00) begin
                e_i = 32'd0;
                e_e = 1'b1;
            end else begin
                e_i = rd;
                e_e = (rr != 2'b00);
            end
            idle_cycles($urandom_range(2));
            do_fetch(rp, rd, rr, $urandom_range(3), $urandom_range(3),
                     ($urandom_range(3) == 0), e_i, e_e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_port.md
# ifu_fetch_port

Instruction-fetch memory port sitting directly below the IFU control FSM. It turns the IFU's single-cycle `reqValid` pulse and the current PC into one AXI4-Lite read transaction on the instruction bus, then returns the fetched word with a single-cycle `respValid` pulse that moves the IFU from WAIT back to IDLE. It also flags fetch faults (misaligned PC, non-OKAY bus response) and counts completed fetches for the performance counters.

## Interface
- `ADDR_W`, default 32: PC and AXI address width.
- `DATA_W`, default 32: instruction and AXI data width. Fixed at 32 for RV32.
- `clock`, input, 1: clock; all state updates on its rising edge.
- `reset`, input, 1: reset, asynchronous, active-high.
- `reqValid`, input, 1: fetch request pulse from the IFU. Sampled only in IDLE.
- `pc`, input, ADDR_W: fetch address, sampled in the same cycle as `reqValid`.
- `respValid`, output, 1: one-cycle pulse; `inst` and `fetch_err` are valid in this cycle.
- `inst`, output, DATA_W: fetched instruction. Held until the next response.
- `fetch_err`, output, 1: fault flag for the current response. Held like `inst`.
- `busy`, output, 1: high in any state other than IDLE.
- `fetch_count`, output, 32: number of completed responses, including errored ones. Wraps.
- `araddr`, output, ADDR_W: AXI read address.
- `arvalid`, output, 1: AXI read address valid.
- `arready`, input, 1: AXI read address ready.
- `rdata`, input, DATA_W: AXI read data.
- `rresp`, input, 2: AXI read response.
- `rvalid`, input, 1: AXI read data valid.
- `rready`, output, 1: AXI read data ready.

## Operation
- States: IDLE, ADDR, DATA, RESP. This is a one-outstanding-transaction machine.
- **IDLE**
  - On `reqValid`, register `pc`.
  - If `pc[1:0] != 0` (misaligned): go to RESP with `inst = 0` and `fetch_err = 1`. No bus traffic is issued.
  - Otherwise: `araddr <= pc`, go to ADDR.
- **ADDR**
  - `arvalid = 1`, and `araddr` is held stable.
  - On `arready`, go to DATA.
  - `arvalid` never drops before the handshake.
- **DATA**
  - `rready = 1`.
  - On `rvalid`: `inst <= rdata`, `fetch_err <= (rresp != 2'b00)`, go to RESP.
  - On an error, `inst` still captures `rdata`.
- **RESP**
  - `respValid = 1` for exactly this one cycle.
  - `fetch_count` increments, wrapping 0xFFFFFFFF → 0.
  - Next state is always IDLE.
- `reqValid` in ADDR, DATA or RESP is ignored. The IFU never issues in those states. No queueing.
- `rvalid` outside DATA and `arready` outside ADDR are ignored.
- `arvalid`, `rready` and `respValid` are decoded from registered state only, with no combinational path from inputs. `busy = (state != IDLE)`.
- Reset, including mid-transaction:
  - State → IDLE.
  - `arvalid`, `rready`, `respValid`, `fetch_err` → 0.
  - `inst`, `araddr`, `fetch_count` → 0.
  - An abandoned AXI transaction is the interconnect's concern; the interconnect resets on the same `reset`.

## Timing
- Zero-wait slave (`arready` and `rvalid` high immediately):
  - `reqValid` at cycle N.
  - `arvalid` at N+1, with AR handshake at N+1.
  - `rready` at N+2, with R handshake at N+2.
  - `respValid` at N+3.
  - Minimum latency is 3 cycles from request to response.
- Each cycle of slave stall on `arready` or `rvalid` adds exactly one cycle.
- Misaligned fetch: `reqValid` at N gives `respValid` at N+1.
- Back-to-back fetches: the IFU returns to IDLE on `respValid`, so the earliest next `reqValid` is one cycle after RESP. The port accepts it because it is already in IDLE.
- `inst` and `fetch_err` are stable from the RESP cycle until the next RESP.

## Test plan
- **Aligned fetch, zero-wait slave.** `pc = 0x8000_0000`, `rdata = 0x0000_0413`, `rresp = 0`.
  - `araddr = 0x8000_0000` with `arvalid` at N+1.
  - `respValid` pulse at N+3, `inst = 0x0000_0413`, `fetch_err = 0`, `fetch_count = 1`.
- **Stalled slave.** `arready` delayed 2 cycles and `rvalid` delayed 3 cycles.
  - `respValid` at N+8.
  - `arvalid` and `araddr` stay stable throughout; `busy = 1` from N+1 through N+8.
- **Misaligned PC.** `pc = 0x8000_0002`.
  - `arvalid` never asserts.
  - `respValid` at N+1 with `inst = 0`, `fetch_err = 1`.
- **Bus error.** `rresp = 2'b10`, `rdata = 0xDEAD_BEEF`.
  - `respValid` with `fetch_err = 1`, `inst = 0xDEAD_BEEF`.
  - The next clean fetch clears `fetch_err` to 0.
- **Reset mid-transaction.** Assert `reset` while in DATA.
  - Immediately: `arvalid = rready = respValid = 0`, `busy = 0`, `fetch_count = 0`.
  - A subsequent fetch completes normally.
- **Ignored inputs and counter wrap.**
  - `reqValid` and a spurious `rvalid` while in ADDR are ignored: exactly one AR handshake and one `respValid` result.
  - Preload `fetch_count` to 0xFFFF_FFFF via a forced request sequence; the next response wraps it to 0.
